// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB word-memory slave; define APB_SLV_WAIT_EN to add the WAIT state and its counter.
// PREADY, PSLVERR and PRDATA are all registered. A write commits only on the completion edge.

module apb_slave_mem #(
   parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
   parameter int          DEPTH       = 64,
   parameter int          WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        PRESETn,
   input  logic        PSEL1,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [31:0] PADDR,
   input  logic [31:0] PWDATA,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR
);

   localparam int          IW       = $clog2(DEPTH);
   localparam logic [32:0] WIN_SPAN = 33'(DEPTH) * 33'd4;

   // A legal build never elaborates this branch; it names the supported parameter range.
   generate
      if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0 ||
          WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_params
      end
   endgenerate

`ifdef APB_SLV_WAIT_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_WAIT = 2'd2} state_t;
   logic [3:0] cnt_q, cnt_nx;
`else
   typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;
`endif

   state_t      state, state_nx;
   logic [31:0] addr_q, wdata_q;
   logic        write_q;
   logic [31:0] mem [DEPTH];

   logic        setup, active;
   logic [31:0] eval_addr;
   logic        eval_write;
   logic [32:0] eval_off;
   logic        eval_err;
   logic [IW-1:0] eval_idx;
   logic        pready_nx, pslverr_nx, mem_we;
   logic [31:0] prdata_nx;

   assign setup  = PSEL1 & ~PENABLE;
   assign active = PSEL1 & PENABLE;

   // In IDLE the transfer being accepted is still on the bus; later states use the latched copy.
   // The 33-bit difference borrows into bit 32 when the address is below the window.
   always_comb begin
      eval_addr  = (state == S_IDLE) ? PADDR  : addr_q;
      eval_write = (state == S_IDLE) ? PWRITE : write_q;
      eval_off   = {1'b0, eval_addr} - {1'b0, ADDR_BASE};
      eval_err   = eval_off[32] | (eval_off >= WIN_SPAN) | (eval_addr[1:0] != 2'b00);
      eval_idx   = IW'(eval_off >> 2);
   end

   always_comb begin
      state_nx = state;
`ifdef APB_SLV_WAIT_EN
      cnt_nx   = cnt_q;
`endif
      case (state)
         S_IDLE: begin
            if (setup) begin
`ifdef APB_SLV_WAIT_EN
               if (WAIT_CYCLES == 0) begin
                  state_nx = S_ACCESS;
               end else begin
                  state_nx = S_WAIT;
                  cnt_nx   = 4'(WAIT_CYCLES);
               end
`else
               state_nx = S_ACCESS;
`endif
            end
         end
`ifdef APB_SLV_WAIT_EN
         S_WAIT: begin
            if (!active) begin
               state_nx = S_IDLE;
               cnt_nx   = '0;
            end else if (cnt_q == 4'd1) begin
               state_nx = S_ACCESS;
               cnt_nx   = '0;
            end else begin
               cnt_nx   = cnt_q - 4'd1;
            end
         end
`endif
         S_ACCESS: state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   // ACCESS always lasts one cycle, so entering it is exactly the PREADY cycle.
   always_comb begin
      pready_nx  = 1'b0;
      pslverr_nx = 1'b0;
      prdata_nx  = '0;
      if (state_nx == S_ACCESS) begin
         pready_nx  = 1'b1;
         pslverr_nx = eval_err;
         if (!eval_write && !eval_err) begin
            prdata_nx = mem[eval_idx];
         end
      end
      mem_we = (state == S_ACCESS) && active && write_q && !PSLVERR;
   end

   always_ff @(posedge clk or negedge PRESETn) begin
      if (!PRESETn) begin
         state   <= S_IDLE;
         PREADY  <= 1'b0;
         PSLVERR <= 1'b0;
         PRDATA  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
      end else begin
         state   <= state_nx;
         PREADY  <= pready_nx;
         PSLVERR <= pslverr_nx;
         PRDATA  <= prdata_nx;
         if (state == S_IDLE && setup) begin
            addr_q  <= PADDR;
            wdata_q <= PWDATA;
            write_q <= PWRITE;
         end
      end
   end

`ifdef APB_SLV_WAIT_EN
   always_ff @(posedge clk or negedge PRESETn) begin
      if (!PRESETn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_nx;
      end
   end
`endif

   always_ff @(posedge clk or negedge PRESETn) begin
      if (!PRESETn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (mem_we) begin
         mem[eval_idx] <= wdata_q;
      end
   end

endmodule
